// File: rtl/spi_ram_burst_slave.sv
// SPI slave fronting a single-port register-array RAM, with auto-incrementing burst
// write and read. The SPI bit clock is clk, and MOSI is sampled on its rising edge.
module spi_ram_burst_slave #(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy,
   output logic frame_err
);
   localparam int unsigned HDR_W   = ADDR_SIZE + 2;
   localparam int unsigned AX_W    = ADDR_SIZE + 1;
   localparam int unsigned PTR_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_MAX = (HDR_W > DATA_SIZE) ? HDR_W : DATA_SIZE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [AX_W-1:0] DEPTH_X = AX_W'(MEM_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_WR, S_RD, S_DRAIN} state_t;

   state_t               state, state_nxt;
   logic [PTR_W-1:0]     ptr, ptr_nxt, ptr_inc, ptr_load, rd_addr;
   logic [HDR_W-2:0]     hdr_shift, hdr_nxt;
   logic [HDR_W-1:0]     hdr_full;
   logic [DATA_SIZE-2:0] rx_shift, rx_nxt;
   logic [DATA_SIZE-2:0] tx_shift, tx_nxt;
   logic [DATA_SIZE-1:0] wr_word, rd_word;
   logic [CNT_W-1:0]     bit_cnt, cnt_nxt;
   logic                 rd_primed, rd_primed_nxt;
   logic                 miso_nxt, ferr_nxt, mem_we;
   logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

   assign hdr_full = {hdr_shift, MOSI};
   assign wr_word  = {rx_shift, MOSI};
   assign ptr_inc  = (ptr == PTR_W'(MEM_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   // Out-of-range header addresses fold back into the array.
   assign ptr_load = PTR_W'({1'b0, hdr_full[ADDR_SIZE-1:0]} % DEPTH_X);

   // Next-state, datapath and registered-output decode; SS_n high aborts any frame.
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      hdr_nxt       = hdr_shift;
      rx_nxt        = rx_shift;
      tx_nxt        = tx_shift;
      cnt_nxt       = bit_cnt;
      rd_primed_nxt = rd_primed;
      rd_addr       = ptr;
      rd_word       = '0;
      miso_nxt      = 1'b0;
      ferr_nxt      = 1'b0;
      mem_we        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!SS_n) begin
               state_nxt = S_HDR;
               cnt_nxt   = '0;
            end
         end
         S_HDR: begin
            if (SS_n) begin
               state_nxt = S_IDLE;
               ferr_nxt  = 1'b1;
            end else begin
               hdr_nxt = (HDR_W-1)'(hdr_full);
               cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(HDR_W - 1)) begin
                  ptr_nxt       = ptr_load;
                  cnt_nxt       = '0;
                  rd_primed_nxt = 1'b0;
                  case (hdr_full[HDR_W-1 -: 2])
                     2'b00:   state_nxt = S_WR;
                     2'b01:   state_nxt = S_RD;
                     default: begin
                        state_nxt = S_DRAIN;
                        ferr_nxt  = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_WR: begin
            if (SS_n) begin
               state_nxt = S_IDLE;
            end else begin
               rx_nxt = (DATA_SIZE-1)'(wr_word);
               if (bit_cnt == CNT_W'(DATA_SIZE - 1)) begin
                  mem_we  = 1'b1;
                  ptr_nxt = ptr_inc;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
         end
         S_RD: begin
            if (SS_n) begin
               state_nxt = S_IDLE;
            end else if (bit_cnt == '0) begin
               // Word boundary: the first load uses the header address, later loads advance.
               rd_addr       = rd_primed ? ptr_inc : ptr;
               rd_word       = mem[rd_addr];
               miso_nxt      = rd_word[DATA_SIZE-1];
               tx_nxt        = rd_word[DATA_SIZE-2:0];
               ptr_nxt       = rd_addr;
               rd_primed_nxt = 1'b1;
               cnt_nxt       = CNT_W'(1);
            end else begin
               miso_nxt = tx_shift[DATA_SIZE-2];
               tx_nxt   = tx_shift << 1;
               cnt_nxt  = (bit_cnt == CNT_W'(DATA_SIZE - 1)) ? '0 : bit_cnt + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (SS_n) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= '0;
         hdr_shift <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         bit_cnt   <= '0;
         rd_primed <= 1'b0;
         MISO      <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hdr_shift <= hdr_nxt;
         rx_shift  <= rx_nxt;
         tx_shift  <= tx_nxt;
         bit_cnt   <= cnt_nxt;
         rd_primed <= rd_primed_nxt;
         MISO      <= miso_nxt;
         busy      <= (state_nxt != S_IDLE);
         frame_err <= ferr_nxt;
      end
   end

   // Storage is deliberately not reset; a reset edge blocks any pending write.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) mem[ptr] <= wr_word;
   end
endmodule
